// File: rtl/load_store_unit.sv
// RV32I data memory behind a req/resp handshake; response LATENCY cycles after accept.
// Single outstanding access: req_ready only in IDLE, response held until resp_ready.
module load_store_unit #(
  parameter int DEPTH   = 32,
  parameter int LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_address,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_rdata,
  output logic                  resp_error,
  input  logic [DEPTH-1:0][31:0] initial_values,
  output logic [DEPTH-1:0][31:0] memory_check
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                 r_state, w_state_nxt;
  logic [3:0]             r_cnt, w_cnt_nxt;
  logic                   r_write;
  logic [2:0]             r_funct3;
  logic [31:0]            r_addr, r_wdata;
  logic [DEPTH-1:0][31:0] r_mem;
  logic [31:0]            r_resp_rdata;
  logic                   r_resp_error;

  logic                   w_access;
  logic                   w_write;
  logic [2:0]             w_funct3;
  logic [31:0]            w_addr, w_wdata;
  logic [AW-1:0]          w_idx;
  logic [4:0]             w_shamt;
  logic [31:0]            w_word, w_shift, w_load, w_mask, w_new;
  logic                   w_oor, w_misalign, w_illegal, w_err;

  // With LATENCY 1 the access happens on the accept edge, before the request is latched.
  assign w_write  = (r_state == IDLE) ? req_write   : r_write;
  assign w_funct3 = (r_state == IDLE) ? req_funct3  : r_funct3;
  assign w_addr   = (r_state == IDLE) ? req_address : r_addr;
  assign w_wdata  = (r_state == IDLE) ? req_wdata   : r_wdata;

  assign w_idx   = w_addr[AW+1:2];
  assign w_shamt = {w_addr[1:0], 3'b000};
  assign w_word  = r_mem[w_idx];
  assign w_shift = w_word >> w_shamt;
  assign w_oor   = |w_addr[31:AW+2];

  always_comb begin
    w_misalign = 1'b0;
    w_illegal  = 1'b0;
    w_mask     = 32'h0;
    w_load     = 32'h0;
    case (w_funct3[1:0])
      2'b00: w_mask = 32'h0000_00FF << w_shamt;
      2'b01: begin
        w_misalign = w_addr[0];
        w_mask     = 32'h0000_FFFF << w_shamt;
      end
      2'b10: begin
        w_misalign = |w_addr[1:0];
        w_mask     = 32'hFFFF_FFFF;
      end
      default: w_illegal = 1'b1;
    endcase
    // Unsigned forms exist only for LBU/LHU loads.
    if (w_funct3[2] && (w_write || w_funct3[1]))
      w_illegal = 1'b1;
    case (w_funct3)
      3'b000:  w_load = {{24{w_shift[7]}}, w_shift[7:0]};
      3'b100:  w_load = {24'h0, w_shift[7:0]};
      3'b001:  w_load = {{16{w_shift[15]}}, w_shift[15:0]};
      3'b101:  w_load = {16'h0, w_shift[15:0]};
      3'b010:  w_load = w_word;
      default: w_load = 32'h0;
    endcase
  end

  assign w_err = w_oor | w_misalign | w_illegal;
  assign w_new = (w_word & ~w_mask) | ((w_wdata << w_shamt) & w_mask);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_access    = 1'b0;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          if (LATENCY == 1) begin
            w_access    = 1'b1;
            w_state_nxt = RESP;
          end else begin
            w_state_nxt = BUSY;
            w_cnt_nxt   = 4'(LATENCY - 2);
          end
        end
      end
      BUSY: begin
        if (r_cnt == 4'd0) begin
          w_access    = 1'b1;
          w_state_nxt = RESP;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      RESP: begin
        if (resp_ready)
          w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_cnt        <= 4'd0;
      r_write      <= 1'b0;
      r_funct3     <= 3'd0;
      r_addr       <= 32'h0;
      r_wdata      <= 32'h0;
      r_resp_rdata <= 32'h0;
      r_resp_error <= 1'b0;
      r_mem        <= initial_values;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (r_state == IDLE && req_valid) begin
        r_write  <= req_write;
        r_funct3 <= req_funct3;
        r_addr   <= req_address;
        r_wdata  <= req_wdata;
      end
      if (w_access) begin
        r_resp_error <= w_err;
        r_resp_rdata <= (w_err || w_write) ? 32'h0 : w_load;
        if (w_write && !w_err)
          r_mem[w_idx] <= w_new;
      end else if (r_state == RESP && resp_ready) begin
        r_resp_error <= 1'b0;
        r_resp_rdata <= 32'h0;
      end
    end
  end

  assign req_ready    = (r_state == IDLE);
  assign resp_valid   = (r_state == RESP);
  assign resp_rdata   = r_resp_rdata;
  assign resp_error   = r_resp_error;
  assign memory_check = r_mem;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: three instances (LATENCY 1, 3, 4) driven by tasks,
// expected responses queued at request time and popped when the response appears.
module tb_load_store_unit;
  localparam int DEPTH = 32;
  localparam int NDUT  = 3;
  localparam logic [NDUT-1:0][3:0] LATS = {4'd4, 4'd3, 4'd1};

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic                   clk;
  logic                   rst         [NDUT];
  logic                   req_valid   [NDUT];
  logic                   req_ready   [NDUT];
  logic                   req_write   [NDUT];
  logic [2:0]             req_funct3  [NDUT];
  logic [31:0]            req_address [NDUT];
  logic [31:0]            req_wdata   [NDUT];
  logic                   resp_valid  [NDUT];
  logic                   resp_ready  [NDUT];
  logic [31:0]            resp_rdata  [NDUT];
  logic                   resp_error  [NDUT];
  logic [DEPTH-1:0][31:0] init_vals;
  logic [DEPTH-1:0][31:0] mem_chk     [NDUT];

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    load_store_unit #(.DEPTH(DEPTH), .LATENCY(int'(LATS[g]))) u_dut (
      .clk            (clk),
      .reset          (rst[g]),
      .req_valid      (req_valid[g]),
      .req_ready      (req_ready[g]),
      .req_write      (req_write[g]),
      .req_funct3     (req_funct3[g]),
      .req_address    (req_address[g]),
      .req_wdata      (req_wdata[g]),
      .resp_valid     (resp_valid[g]),
      .resp_ready     (resp_ready[g]),
      .resp_rdata     (resp_rdata[g]),
      .resp_error     (resp_error[g]),
      .initial_values (init_vals),
      .memory_check   (mem_chk[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic txn(input int d, input logic wr, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wd,
                     input logic [31:0] exp_rd, input logic exp_err,
                     input int hold, input string tag);
    exp_t e;
    int   lat;
    @(negedge clk);
    chk({tag, "_req_rdy"}, 32'(req_ready[d]), 32'd1);
    req_valid[d]   = 1'b1;
    req_write[d]   = wr;
    req_funct3[d]  = f3;
    req_address[d] = addr;
    req_wdata[d]   = wd;
    sb.push_back('{rdata: exp_rd, err: exp_err});
    @(negedge clk);
    // Scramble inputs after accept; the latched request must be used.
    req_valid[d]   = 1'b0;
    req_funct3[d]  = 3'b000;
    req_address[d] = 32'h0000_0004;
    req_wdata[d]   = 32'hFFFF_FFFF;
    lat = 1;
    while (!resp_valid[d] && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(LATS[d]));
    chk({tag, "_sbsz"}, 32'(sb.size()), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_rdata"}, resp_rdata[d], e.rdata);
      chk({tag, "_err"}, 32'(resp_error[d]), 32'(e.err));
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk({tag, "_hold_vld"}, 32'(resp_valid[d]), 32'd1);
        chk({tag, "_hold_rdata"}, resp_rdata[d], e.rdata);
        chk({tag, "_hold_rdy"}, 32'(req_ready[d]), 32'd0);
      end
    end
    resp_ready[d] = 1'b1;
    @(negedge clk);
    resp_ready[d] = 1'b0;
    chk({tag, "_post_vld"}, 32'(resp_valid[d]), 32'd0);
    chk({tag, "_post_rdy"}, 32'(req_ready[d]), 32'd1);
    chk({tag, "_post_rdata"}, resp_rdata[d], 32'h0);
  endtask

  initial begin
    exp_t e;
    int   acc_cyc [2];
    int   n_acc;
    int   n_resp;
    int   seen_rv;

    for (int i = 0; i < DEPTH; i++)
      init_vals[i] = 32'h1000_0000 + 32'(i) * 32'h0001_0203;
    init_vals[1] = 32'h80FF_7F01;
    for (int d = 0; d < NDUT; d++) begin
      rst[d] = 1'b1; req_valid[d] = 1'b0; req_write[d] = 1'b0; req_funct3[d] = 3'd0;
      req_address[d] = 32'h0; req_wdata[d] = 32'h0; resp_ready[d] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < NDUT; d++) rst[d] = 1'b0;
    @(negedge clk);

    chk("rst_vld", 32'(resp_valid[0]), 32'd0);
    chk("rst_rdata", resp_rdata[0], 32'h0);
    chk("rst_err", 32'(resp_error[0]), 32'd0);
    chk("rst_rdy", 32'(req_ready[0]), 32'd1);
    chk("rst_mem1", mem_chk[0][1], 32'h80FF_7F01);

    // Loads on LATENCY 1.
    txn(0, 1'b0, 3'b000, 32'd7, 32'h0, 32'hFFFF_FF80, 1'b0, 0, "lb7");
    txn(0, 1'b0, 3'b100, 32'd7, 32'h0, 32'h0000_0080, 1'b0, 0, "lbu7");
    txn(0, 1'b0, 3'b001, 32'd6, 32'h0, 32'hFFFF_80FF, 1'b0, 0, "lh6");
    txn(0, 1'b0, 3'b101, 32'd4, 32'h0, 32'h0000_7F01, 1'b0, 0, "lhu4");
    txn(0, 1'b0, 3'b010, 32'd4, 32'h0, 32'h80FF_7F01, 1'b0, 0, "lw4");

    // Sub-word stores.
    txn(0, 1'b1, 3'b000, 32'd5, 32'h1234_56AB, 32'h0, 1'b0, 0, "sb5");
    chk("sb5_mem", mem_chk[0][1], 32'h80FF_AB01);
    txn(0, 1'b1, 3'b001, 32'd6, 32'h0000_BEEF, 32'h0, 1'b0, 0, "sh6");
    chk("sh6_mem", mem_chk[0][1], 32'hBEEF_AB01);

    // Faults.
    txn(0, 1'b0, 3'b010, 32'd6, 32'h0, 32'h0, 1'b1, 0, "lw6_mis");
    txn(0, 1'b1, 3'b001, 32'd3, 32'hAAAA_5555, 32'h0, 1'b1, 0, "sh3_mis");
    chk("sh3_mem0", mem_chk[0][0], init_vals[0]);
    txn(0, 1'b0, 3'b010, 32'd128, 32'h0, 32'h0, 1'b1, 0, "lw128_oor");
    txn(0, 1'b0, 3'b011, 32'd4, 32'h0, 32'h0, 1'b1, 0, "ld011_ill");
    txn(0, 1'b1, 3'b100, 32'd4, 32'h0, 32'h0, 1'b1, 0, "st100_ill");
    chk("fault_mem1", mem_chk[0][1], 32'hBEEF_AB01);

    // Latency 3 with backpressure, plus an error response at full latency.
    txn(1, 1'b0, 3'b010, 32'd4, 32'h0, 32'h80FF_7F01, 1'b0, 4, "l3_lw4");
    txn(1, 1'b0, 3'b000, 32'd7, 32'h0, 32'hFFFF_FF80, 1'b0, 0, "l3_lb7");
    txn(1, 1'b1, 3'b010, 32'd2, 32'h0, 32'h0, 1'b1, 2, "l3_sw_mis");

    // Back-to-back: SW @0 then LW @0 with req_valid and resp_ready held high.
    @(negedge clk);
    req_valid[1] = 1'b1; req_write[1] = 1'b1; req_funct3[1] = 3'b010;
    req_address[1] = 32'h0; req_wdata[1] = 32'hCAFE_F00D; resp_ready[1] = 1'b1;
    n_acc = 0; n_resp = 0; acc_cyc[0] = 0; acc_cyc[1] = 0;
    for (int cyc = 0; cyc < 40 && n_resp < 2; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (n_acc == 1) begin req_write[1] = 1'b0; req_wdata[1] = 32'h0; end
      if (n_acc == 2) req_valid[1] = 1'b0;
      if (resp_valid[1]) begin
        chk("b2b_sbsz", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("b2b_rdata", resp_rdata[1], e.rdata);
          chk("b2b_err", 32'(resp_error[1]), 32'(e.err));
        end
        n_resp++;
      end
      if (req_valid[1] && req_ready[1] && n_acc < 2) begin
        acc_cyc[n_acc] = cyc;
        sb.push_back('{rdata: (n_acc == 0) ? 32'h0 : 32'hCAFE_F00D, err: 1'b0});
        n_acc++;
      end
    end
    req_valid[1] = 1'b0; resp_ready[1] = 1'b0;
    chk("b2b_nresp", 32'(n_resp), 32'd2);
    chk("b2b_space", 32'(acc_cyc[1] - acc_cyc[0]), 32'(LATS[1]) + 32'd1);
    chk("b2b_mem0", mem_chk[1][0], 32'hCAFE_F00D);

    // Reset during a LATENCY 4 store: nothing commits, no response.
    @(negedge clk);
    chk("rstmid_rdy0", 32'(req_ready[2]), 32'd1);
    req_valid[2] = 1'b1; req_write[2] = 1'b1; req_funct3[2] = 3'b010;
    req_address[2] = 32'd8; req_wdata[2] = 32'hDEAD_BEEF;
    seen_rv = 0;
    @(negedge clk);
    req_valid[2] = 1'b0;
    if (resp_valid[2]) seen_rv++;
    @(negedge clk);
    if (resp_valid[2]) seen_rv++;
    rst[2] = 1'b1;
    @(negedge clk);
    rst[2] = 1'b0;
    if (resp_valid[2]) seen_rv++;
    @(negedge clk);
    chk("rstmid_rdy", 32'(req_ready[2]), 32'd1);
    for (int i = 0; i < 8; i++) begin
      if (resp_valid[2]) seen_rv++;
      @(negedge clk);
    end
    chk("rstmid_rv", 32'(seen_rv), 32'd0);
    chk("rstmid_mem2", mem_chk[2][2], init_vals[2]);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
